// File: rtl/brq_ifu_fetch_fifo_pkg.sv
// Shared types and helpers for the brq IF-stage fetch FIFO and its aligner.
// Combinational helpers only; no timing or flow-control behaviour of its own.
package brq_ifu_pkg;

    localparam int IFU_INSTR_W = 32;

    typedef struct packed {
        logic [IFU_INSTR_W-1:0] rdata;
        logic                   err;
    } ifu_fifo_entry_t;

    // A 16-bit parcel is a compressed instruction unless its opcode bits are 2'b11.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/brq_ifu_fetch_fifo_if.sv
// Fetch-response in / instruction out bundle of the IF-stage fetch FIFO.
// Valid/ready on the output side; input side is push-only, drops on overflow.
interface brq_ifu_fetch_fifo_if #(
    parameter int NUM_REQS = 2
);
    localparam int DEPTH = NUM_REQS + 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                clear_i;
    logic [NUM_REQS-1:0] busy_o;
    logic [LVL_W-1:0]    level_o;
    logic                overflow_o;
    logic                in_valid_i;
    logic [31:0]         in_addr_i;
    logic [31:0]         in_rdata_i;
    logic                in_err_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         out_addr_o;
    logic [31:0]         out_addr_next_o;
    logic [31:0]         out_rdata_o;
    logic                out_err_o;
    logic                out_err_plus2_o;
    logic                out_compressed_o;

    modport master (
        output clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
        input  busy_o, level_o, overflow_o, out_valid_o, out_addr_o, out_addr_next_o,
               out_rdata_o, out_err_o, out_err_plus2_o, out_compressed_o
    );

    modport slave (
        input  clear_i, in_valid_i, in_addr_i, in_rdata_i, in_err_i, out_ready_i,
        output busy_o, level_o, overflow_o, out_valid_o, out_addr_o, out_addr_next_o,
               out_rdata_o, out_err_o, out_err_plus2_o, out_compressed_o
    );
endinterface

// File: rtl/brq_ifu_fetch_fifo_aligner.sv
// Builds one instruction from the head entry, the next entry and PC[1].
// Purely combinational; valid only when every half it needs is present.
module brq_ifu_fetch_aligner
    import brq_ifu_pkg::*;
(
    input  ifu_fifo_entry_t        entry0_i,
    input  logic                   entry0_vld_i,
    input  ifu_fifo_entry_t        entry1_i,
    input  logic                   entry1_vld_i,
    input  logic                   pc1_i,
    output logic [IFU_INSTR_W-1:0] rdata_o,
    output logic                   err_o,
    output logic                   err_plus2_o,
    output logic                   valid_o,
    output logic                   compressed_o
);

`ifdef BRQ_IFU_FIFO_RVC_EN
    logic [15:0] lo_half;

    always_comb begin
        rdata_o     = entry0_i.rdata;
        err_o       = entry0_i.err;
        err_plus2_o = 1'b0;
        valid_o     = entry0_vld_i;
        lo_half     = entry0_i.rdata[15:0];
        if (pc1_i) begin
            lo_half = entry0_i.rdata[31:16];
            rdata_o = {entry1_i.rdata[15:0], lo_half};
            // A 32-bit instruction straddling two words needs both halves.
            if (!is_compressed(lo_half)) begin
                valid_o     = entry0_vld_i & entry1_vld_i;
                err_o       = entry0_i.err | entry1_i.err;
                err_plus2_o = entry1_i.err & ~entry0_i.err;
            end
        end
        compressed_o = is_compressed(lo_half) & ~err_o;
    end
`else
    logic unused_aligner;

    assign rdata_o        = entry0_i.rdata;
    assign err_o          = entry0_i.err;
    assign err_plus2_o    = 1'b0;
    assign valid_o        = entry0_vld_i;
    assign compressed_o   = 1'b0;
    assign unused_aligner = ^{entry1_i, entry1_vld_i, pc1_i};
`endif

endmodule

// File: rtl/brq_ifu_fetch_fifo.sv
// Shifting fetch FIFO with PC tracking; BRQ_IFU_FIFO_RVC_EN enables RVC realignment.
// Latency 0 (BYPASS=1) or 1 cycle; out_ready_i stalls the head, pushes while full set overflow_o.
module brq_ifu_fetch_fifo
    import brq_ifu_pkg::*;
#(
    parameter int NUM_REQS = 2,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    brq_ifu_fetch_fifo_if.slave        fifo_if
);

    localparam int DEPTH = NUM_REQS + 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    ifu_fifo_entry_t entry_q [DEPTH];
    ifu_fifo_entry_t entry_d [DEPTH];
    ifu_fifo_entry_t entry_s [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, valid_s, wr_sel;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [31:1]      pc_q, pc_d;

    ifu_fifo_entry_t  in_entry, head, next;
    logic             bypass_vld, head_vld, next_vld;
    logic [31:0]      al_rdata, out_addr, addr_next;
    logic             al_err, al_err_plus2, al_valid, al_compressed;
    logic             handshake, pop, shift, push, store;
    logic             unused_addr;

    assign in_entry   = '{rdata: fifo_if.in_rdata_i, err: fifo_if.in_err_i};
    assign bypass_vld = BYPASS & fifo_if.in_valid_i & ~fifo_if.clear_i;

    // The incoming word stands in for the first missing stored entry.
    assign head     = valid_q[0] ? entry_q[0] : in_entry;
    assign head_vld = valid_q[0] | bypass_vld;
    assign next     = valid_q[1] ? entry_q[1] : in_entry;
    assign next_vld = valid_q[1] | (valid_q[0] & bypass_vld);

    brq_ifu_fetch_aligner u_aligner (
        .entry0_i     (head),
        .entry0_vld_i (head_vld),
        .entry1_i     (next),
        .entry1_vld_i (next_vld),
        .pc1_i        (pc_q[1]),
        .rdata_o      (al_rdata),
        .err_o        (al_err),
        .err_plus2_o  (al_err_plus2),
        .valid_o      (al_valid),
        .compressed_o (al_compressed)
    );

    assign out_addr  = {pc_q, 1'b0};
    assign addr_next = out_addr + (al_compressed ? 32'd2 : 32'd4);
    assign handshake = al_valid & fifo_if.out_ready_i;

`ifdef BRQ_IFU_FIFO_RVC_EN
    // An aligned compressed instruction leaves its upper half in the head entry.
    assign pop = handshake & (pc_q[1] | ~al_compressed);
`else
    assign pop = handshake;
`endif

    assign shift  = pop & valid_q[0];
    // A pop with nothing stored consumed the bypassed word itself.
    assign push   = fifo_if.in_valid_i & ~fifo_if.clear_i & ~(pop & ~valid_q[0]);
    assign wr_sel = ~valid_s & {valid_s[DEPTH-2:0], 1'b1};
    assign store  = push & ~valid_s[DEPTH-1];

    always_comb begin
        valid_s = valid_q;
        for (int i = 0; i < DEPTH; i++) entry_s[i] = entry_q[i];
        if (shift) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entry_s[i] = entry_q[i+1];
                valid_s[i] = valid_q[i+1];
            end
            valid_s[DEPTH-1] = 1'b0;
        end
    end

    always_comb begin
        valid_d    = valid_s;
        for (int i = 0; i < DEPTH; i++) entry_d[i] = entry_s[i];
        level_d    = level_q + LVL_W'(store) - LVL_W'(shift);
        overflow_d = overflow_q | (push & valid_s[DEPTH-1]);
        pc_d       = handshake ? addr_next[31:1] : pc_q;
        if (store) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    entry_d[i] = in_entry;
                    valid_d[i] = 1'b1;
                end
            end
        end
        if (fifo_if.clear_i) begin
            valid_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
`ifdef BRQ_IFU_FIFO_RVC_EN
            pc_d       = fifo_if.in_addr_i[31:1];
`else
            pc_d       = {fifo_if.in_addr_i[31:2], 1'b0};
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            valid_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            valid_q    <= valid_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            pc_q       <= pc_d;
        end
    end

    assign fifo_if.busy_o           = valid_q[DEPTH-1 -: NUM_REQS];
    assign fifo_if.level_o          = level_q;
    assign fifo_if.overflow_o       = overflow_q;
    assign fifo_if.out_valid_o      = al_valid;
    assign fifo_if.out_addr_o       = out_addr;
    assign fifo_if.out_addr_next_o  = addr_next;
    assign fifo_if.out_rdata_o      = al_rdata;
    assign fifo_if.out_err_o        = al_err;
    assign fifo_if.out_err_plus2_o  = al_err_plus2;
    assign fifo_if.out_compressed_o = al_compressed;
    assign unused_addr              = ^fifo_if.in_addr_i[1:0];

endmodule

// File: tb/tb_brq_ifu_fetch_fifo.sv
// Bench for brq_ifu_fetch_fifo: directed corner sequences, an overflow vector table
// and a random run against a queue-based reference model (BYPASS=1 and BYPASS=0).
module tb_brq_ifu_fetch_fifo;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } ent_t;

    typedef struct {
        logic       clr;
        logic       vld;
        logic       rdy;
        int         lvl;
        logic [2:0] busy;
        logic       ovf;
        logic       ov;
    } ovf_vec_t;

    localparam int DEPTH_AB = 3;
    localparam int NR_AB    = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    brq_ifu_fetch_fifo_if #(.NUM_REQS(2)) ifa ();
    brq_ifu_fetch_fifo_if #(.NUM_REQS(2)) ifb ();
    brq_ifu_fetch_fifo_if #(.NUM_REQS(3)) ifc ();

    brq_ifu_fetch_fifo #(.NUM_REQS(2), .BYPASS(1'b1)) dut_a (.clk_i(clk), .rst_ni(rst_n), .fifo_if(ifa));
    brq_ifu_fetch_fifo #(.NUM_REQS(2), .BYPASS(1'b0)) dut_b (.clk_i(clk), .rst_ni(rst_n), .fifo_if(ifb));
    brq_ifu_fetch_fifo #(.NUM_REQS(3), .BYPASS(1'b1)) dut_c (.clk_i(clk), .rst_ni(rst_n), .fifo_if(ifc));

    always #5 clk = ~clk;

    // Stimulus shared by the A and B instances in the random run.
    logic        s_clear, s_vld, s_err, s_rdy;
    logic [31:0] s_addr, s_rdata;

    ent_t        mq0[$];
    ent_t        mq1[$];
    logic [31:0] mpc [2];
    logic        movf [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ab(input logic clr, input logic vld, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic err, input logic rdy);
        ifa.clear_i = clr; ifa.in_valid_i = vld; ifa.in_addr_i = addr;
        ifa.in_rdata_i = rdata; ifa.in_err_i = err; ifa.out_ready_i = rdy;
        ifb.clear_i = clr; ifb.in_valid_i = vld; ifb.in_addr_i = addr;
        ifb.in_rdata_i = rdata; ifb.in_err_i = err; ifb.out_ready_i = rdy;
    endtask

    // Reference: the FIFO is a queue of words; with bypass the incoming word is
    // appended to the visible queue before the instruction is picked from it.
    task automatic model_cycle(input int d, input logic byp);
        ent_t q[$];
        ent_t view[$];
        ent_t inw;
        logic v, err, p2, c, craw, hs, popd, consumed;
        logic [31:0] rd, pc, nxt, ebusy;
        logic [15:0] lo;
        logic a_ov, a_err, a_p2, a_c, a_ovf;
        logic [31:0] a_rd, a_addr, a_next, a_lvl, a_busy;
        string pfx;

        if (d == 0) begin
            q = mq0; pfx = "A.";
            a_ov = ifa.out_valid_o; a_err = ifa.out_err_o; a_p2 = ifa.out_err_plus2_o;
            a_c = ifa.out_compressed_o; a_ovf = ifa.overflow_o; a_rd = ifa.out_rdata_o;
            a_addr = ifa.out_addr_o; a_next = ifa.out_addr_next_o;
            a_lvl = 32'(ifa.level_o); a_busy = 32'(ifa.busy_o);
        end else begin
            q = mq1; pfx = "B.";
            a_ov = ifb.out_valid_o; a_err = ifb.out_err_o; a_p2 = ifb.out_err_plus2_o;
            a_c = ifb.out_compressed_o; a_ovf = ifb.overflow_o; a_rd = ifb.out_rdata_o;
            a_addr = ifb.out_addr_o; a_next = ifb.out_addr_next_o;
            a_lvl = 32'(ifb.level_o); a_busy = 32'(ifb.busy_o);
        end
        pc  = mpc[d];
        inw = '{rdata: s_rdata, err: s_err};
        view = q;
        if (byp && s_vld && !s_clear) view.push_back(inw);

        v = 0; err = 0; p2 = 0; c = 0; craw = 0; rd = '0;
`ifdef BRQ_IFU_FIFO_RVC_EN
        if (view.size() > 0 && !pc[1]) begin
            v = 1; rd = view[0].rdata; err = view[0].err;
            craw = (rd[1:0] != 2'b11);
        end else if (view.size() > 0) begin
            lo = view[0].rdata[31:16];
            craw = (lo[1:0] != 2'b11);
            if (craw) begin
                v = 1; err = view[0].err; rd = {16'h0, lo};
            end else if (view.size() > 1) begin
                v = 1; err = view[0].err | view[1].err;
                p2 = view[1].err & ~view[0].err;
                rd = {view[1].rdata[15:0], lo};
            end
        end
        c = craw & ~err;
`else
        if (view.size() > 0) begin
            v = 1; rd = view[0].rdata; err = view[0].err;
        end
`endif
        nxt = pc + (c ? 32'd2 : 32'd4);
        ebusy = '0;
        for (int i = 0; i < NR_AB; i++) ebusy[i] = (q.size() > DEPTH_AB - NR_AB + i);

        chk({pfx, "out_valid"}, 32'(a_ov), 32'(v));
        chk({pfx, "level"}, a_lvl, 32'(q.size()));
        chk({pfx, "busy"}, a_busy, ebusy);
        chk({pfx, "overflow"}, 32'(a_ovf), 32'(movf[d]));
        chk({pfx, "out_addr"}, a_addr, pc);
        if (v) begin
            chk({pfx, "addr_next"}, a_next, nxt);
            chk({pfx, "err"}, 32'(a_err), 32'(err));
            chk({pfx, "err_plus2"}, 32'(a_p2), 32'(p2));
            chk({pfx, "compressed"}, 32'(a_c), 32'(c));
            if (pc[1] && craw) chk({pfx, "rdata_lo"}, {16'h0, a_rd[15:0]}, rd);
            else               chk({pfx, "rdata"}, a_rd, rd);
        end

        if (s_clear) begin
            q.delete();
`ifdef BRQ_IFU_FIFO_RVC_EN
            mpc[d] = s_addr & 32'hFFFF_FFFE;
`else
            mpc[d] = s_addr & 32'hFFFF_FFFC;
`endif
            movf[d] = 1'b0;
        end else begin
            hs = v & s_rdy;
            consumed = 0;
`ifdef BRQ_IFU_FIFO_RVC_EN
            popd = hs & (pc[1] | ~c);
`else
            popd = hs;
`endif
            if (hs) mpc[d] = nxt;
            if (popd) begin
                if (q.size() > 0) void'(q.pop_front());
                else consumed = 1;
            end
            if (s_vld && !consumed) begin
                if (q.size() < DEPTH_AB) q.push_back(inw);
                else movf[d] = 1'b1;
            end
        end
        if (d == 0) mq0 = q;
        else        mq1 = q;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ovf_vec_t tbl [9];
        tbl[0] = '{clr: 0, vld: 1, rdy: 0, lvl: 1, busy: 3'b000, ovf: 0, ov: 1};
        tbl[1] = '{clr: 0, vld: 1, rdy: 0, lvl: 2, busy: 3'b001, ovf: 0, ov: 1};
        tbl[2] = '{clr: 0, vld: 1, rdy: 0, lvl: 3, busy: 3'b011, ovf: 0, ov: 1};
        tbl[3] = '{clr: 0, vld: 1, rdy: 0, lvl: 4, busy: 3'b111, ovf: 0, ov: 1};
        tbl[4] = '{clr: 0, vld: 1, rdy: 0, lvl: 4, busy: 3'b111, ovf: 1, ov: 1};
        tbl[5] = '{clr: 0, vld: 1, rdy: 1, lvl: 4, busy: 3'b111, ovf: 1, ov: 1};
        tbl[6] = '{clr: 0, vld: 0, rdy: 1, lvl: 3, busy: 3'b011, ovf: 1, ov: 1};
        tbl[7] = '{clr: 1, vld: 0, rdy: 0, lvl: 0, busy: 3'b000, ovf: 0, ov: 0};
        tbl[8] = '{clr: 0, vld: 0, rdy: 0, lvl: 0, busy: 3'b000, ovf: 0, ov: 0};

        rst_n = 1'b0;
        set_ab(0, 0, 0, 0, 0, 0);
        ifc.clear_i = 0; ifc.in_valid_i = 0; ifc.in_addr_i = 0;
        ifc.in_rdata_i = 0; ifc.in_err_i = 0; ifc.out_ready_i = 0;
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("reset.level", 32'(ifa.level_o), 0);
        chk("reset.out_valid", 32'(ifa.out_valid_o), 0);
        chk("reset.out_addr", ifa.out_addr_o, 0);
        chk("reset.overflow", 32'(ifa.overflow_o), 0);
        chk("reset.busy", 32'(ifc.busy_o), 0);

        // Reset in the middle of traffic with two entries held.
        cyc(); set_ab(1, 0, 32'h40, 0, 0, 0);
        cyc(); set_ab(0, 1, 0, 32'h0000_0013, 0, 0);
        cyc(); set_ab(0, 1, 0, 32'h0040_0093, 0, 0);
        cyc(); set_ab(0, 0, 0, 0, 0, 0);
        #1;
        chk("mid.level_a", 32'(ifa.level_o), 2);
        chk("mid.level_b", 32'(ifb.level_o), 2);
        chk("mid.addr", ifa.out_addr_o, 32'h40);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("mrst.level", 32'(ifa.level_o), 0);
        chk("mrst.out_valid", 32'(ifa.out_valid_o), 0);
        chk("mrst.out_addr", ifa.out_addr_o, 0);
        chk("mrst.overflow", 32'(ifa.overflow_o), 0);
        chk("mrst.level_b", 32'(ifb.level_o), 0);

        // Zero-latency bypass on A versus one-cycle latency on B.
        set_ab(0, 1, 0, 32'h00A0_0093, 0, 1);
        #1;
        chk("byp.a_valid", 32'(ifa.out_valid_o), 1);
        chk("byp.a_rdata", ifa.out_rdata_o, 32'h00A0_0093);
        chk("byp.b_valid", 32'(ifb.out_valid_o), 0);
        cyc(); set_ab(0, 0, 0, 0, 0, 0);
        #1;
        chk("byp.a_level", 32'(ifa.level_o), 0);
        chk("byp.a_valid_after", 32'(ifa.out_valid_o), 0);
        chk("byp.a_addr", ifa.out_addr_o, 32'h4);
        chk("byp.b_valid_after", 32'(ifb.out_valid_o), 1);
        chk("byp.b_level", 32'(ifb.level_o), 1);
        chk("byp.b_rdata", ifb.out_rdata_o, 32'h00A0_0093);
        set_ab(0, 0, 0, 0, 0, 1);
        cyc(); set_ab(0, 0, 0, 0, 0, 0);
        #1;
        chk("byp.b_drained", 32'(ifb.level_o), 0);
        chk("byp.b_addr", ifb.out_addr_o, 32'h4);

        // Realignment / PC stepping after a clear.
`ifdef BRQ_IFU_FIFO_RVC_EN
        set_ab(1, 0, 32'h100, 0, 0, 0);
`else
        set_ab(1, 0, 32'h102, 0, 0, 0);
`endif
        cyc(); set_ab(0, 1, 0, 32'h0003_0001, 0, 0);
        cyc(); set_ab(0, 1, 0, 32'h0000_0513, 0, 0);
        cyc(); set_ab(0, 0, 0, 0, 0, 0);
        #1;
        chk("seq.level", 32'(ifa.level_o), 2);
        chk("seq.valid", 32'(ifa.out_valid_o), 1);
        chk("seq.addr0", ifa.out_addr_o, 32'h100);
`ifdef BRQ_IFU_FIFO_RVC_EN
        chk("seq.rdata0", {16'h0, ifa.out_rdata_o[15:0]}, 32'h0001);
        chk("seq.comp0", 32'(ifa.out_compressed_o), 1);
        chk("seq.next0", ifa.out_addr_next_o, 32'h102);
        set_ab(0, 0, 0, 0, 0, 1); cyc(); set_ab(0, 0, 0, 0, 0, 0); #1;
        chk("seq.addr1", ifa.out_addr_o, 32'h102);
        chk("seq.level1", 32'(ifa.level_o), 2);
        chk("seq.rdata1", ifa.out_rdata_o, 32'h0513_0003);
        chk("seq.comp1", 32'(ifa.out_compressed_o), 0);
        chk("seq.next1", ifa.out_addr_next_o, 32'h106);
        set_ab(0, 0, 0, 0, 0, 1); cyc(); set_ab(0, 0, 0, 0, 0, 0); #1;
        chk("seq.addr2", ifa.out_addr_o, 32'h106);
        chk("seq.level2", 32'(ifa.level_o), 1);
        chk("seq.comp2", 32'(ifa.out_compressed_o), 1);
        chk("seq.next2", ifa.out_addr_next_o, 32'h108);
        set_ab(0, 0, 0, 0, 0, 1); cyc(); set_ab(0, 0, 0, 0, 0, 0); #1;
        chk("seq.addr3", ifa.out_addr_o, 32'h108);
        chk("seq.level3", 32'(ifa.level_o), 0);
`else
        chk("seq.rdata0", ifa.out_rdata_o, 32'h0003_0001);
        chk("seq.comp0", 32'(ifa.out_compressed_o), 0);
        chk("seq.next0", ifa.out_addr_next_o, 32'h104);
        set_ab(0, 0, 0, 0, 0, 1); cyc(); set_ab(0, 0, 0, 0, 0, 0); #1;
        chk("seq.addr1", ifa.out_addr_o, 32'h104);
        chk("seq.level1", 32'(ifa.level_o), 1);
        set_ab(0, 0, 0, 0, 0, 1); cyc(); set_ab(0, 0, 0, 0, 0, 0); #1;
        chk("seq.addr2", ifa.out_addr_o, 32'h108);
        chk("seq.level2", 32'(ifa.level_o), 0);
`endif

        // Error in the upper half of a straddling 32-bit instruction.
        set_ab(1, 0, 32'h102, 0, 0, 0);
        cyc(); set_ab(0, 1, 0, 32'h0003_7000, 0, 0);
        cyc(); set_ab(0, 1, 0, 32'h1234_5678, 1, 0);
        cyc(); set_ab(0, 0, 0, 0, 0, 0);
        #1;
        chk("err.valid", 32'(ifa.out_valid_o), 1);
`ifdef BRQ_IFU_FIFO_RVC_EN
        chk("err.err", 32'(ifa.out_err_o), 1);
        chk("err.plus2", 32'(ifa.out_err_plus2_o), 1);
        chk("err.comp", 32'(ifa.out_compressed_o), 0);
        chk("err.rdata", ifa.out_rdata_o, 32'h5678_0003);
`else
        chk("err.err", 32'(ifa.out_err_o), 0);
        chk("err.plus2", 32'(ifa.out_err_plus2_o), 0);
        chk("err.rdata", ifa.out_rdata_o, 32'h0003_7000);
`endif
        set_ab(1, 0, 0, 0, 0, 0); cyc(); set_ab(0, 0, 0, 0, 0, 0);

        // Fill / overflow / clear table on the four-entry instance.
        for (int i = 0; i < 9; i++) begin
            ifc.clear_i = tbl[i].clr;
            ifc.in_valid_i = tbl[i].vld;
            ifc.out_ready_i = tbl[i].rdy;
            ifc.in_rdata_i = 32'h00A0_0093 + (i << 8);
            cyc();
            ifc.clear_i = 0; ifc.in_valid_i = 0; ifc.out_ready_i = 0;
            #1;
            chk($sformatf("tbl%0d.level", i), 32'(ifc.level_o), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d.busy", i), 32'(ifc.busy_o), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.overflow", i), 32'(ifc.overflow_o), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.out_valid", i), 32'(ifc.out_valid_o), 32'(tbl[i].ov));
        end

        // Random traffic on A and B against the queue model.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        mq0.delete(); mq1.delete();
        mpc[0] = '0; mpc[1] = '0; movf[0] = 1'b0; movf[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            s_clear = ($urandom_range(0, 39) == 0);
            s_vld   = ($urandom_range(0, 9) < 6);
            s_rdy   = ($urandom_range(0, 1) == 1);
            s_err   = ($urandom_range(0, 11) == 0);
            s_addr  = $urandom;
            s_rdata = $urandom;
            if ($urandom_range(0, 1) == 1) s_rdata[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) s_rdata[17:16] = 2'b11;
            set_ab(s_clear, s_vld, s_addr, s_rdata, s_err, s_rdy);
            #1;
            model_cycle(0, 1'b1);
            model_cycle(1, 1'b0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
